// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style UART receive stage driven by a shared oversampling tick.
// Synchronizes rx, finds the start bit, samples each data bit mid-bit, checks the stop bit.
// Ports:
//   clk, arst_n  - clock, asynchronous active-low reset
//   rx           - asynchronous serial line (idle high)
//   tick         - one-clk strobe at OVERSAMPLE x baud
//   rx_data      - last correctly framed word
//   rx_valid     - one-cycle pulse when rx_data is updated
//   frame_err    - one-cycle pulse when the stop bit is sampled low
//   busy         - high whenever the receiver is not idle
module uart_receiver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx,
  input  logic                  tick,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned S_W = $clog2(OVERSAMPLE);
  localparam int unsigned N_W = $clog2(DATA_WIDTH + 1);

  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [S_W-1:0]        s_cnt_q, s_cnt_d;
  logic [N_W-1:0]        n_cnt_q, n_cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;
  logic                  sync_q;
  logic                  rx_s;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rx;
      rx_s   <= sync_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath logic; everything but the IDLE exit waits for a tick.
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (s_cnt_q == S_HALF) begin
            // Line must still be low at mid start bit, otherwise it was a glitch.
            if (!rx_s) begin
              state_d = ST_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            // LSB first: first bit shifts all the way down to sh[0].
            sh_d    = {rx_s, sh_q[DATA_WIDTH-1:1]};
            s_cnt_d = '0;
            n_cnt_d = n_cnt_q + N_W'(1);
            if (n_cnt_q == N_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            if (rx_s) begin
              rx_data_d  = sh_q;
              rx_valid_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end

      ST_BREAK: begin
        // Wait out a held-low line so it cannot retrigger a frame.
        if (tick && rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames are generated at the bit level and the
// received words / framing errors are compared with a frame-level expectation model.
module tb_uart_receiver;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          rx = 1'b1;
  logic          tick = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;

  int tests_run = 0;
  int fails = 0;

  int tick_div = 1;
  int tick_cnt = 0;

  logic [DW-1:0] got_q[$];
  int            err_cnt = 0;
  int            valid_run = 0;
  int            max_valid_run = 0;
  int            both_hi = 0;

  logic [DW-1:0] last_good = '0;

  uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rx        (rx),
    .tick      (tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Tick strobe: one clk high every tick_div clocks, changed away from the active edge.
  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick = 1'b1;
      tick_cnt = 0;
    end else begin
      tick = 1'b0;
      tick_cnt = tick_cnt + 1;
    end
  end

  // Output monitor: records received words, error pulses and pulse widths.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      valid_run = valid_run + 1;
      if (valid_run > max_valid_run) max_valid_run = valid_run;
    end else begin
      valid_run = 0;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (rx_valid && frame_err) both_hi = both_hi + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got_q.delete();
    err_cnt = 0;
    max_valid_run = 0;
    both_hi = 0;
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick) c++;
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle_ticks(input int n);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // Idle the line, then wait (bounded) for the receiver to go quiet.
  task automatic settle();
    int c;
    idle_ticks(OS);
    c = 0;
    while (busy && c < 5000) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    tests_run++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests_run++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    arst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_frame();
    tick_div = 1;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    settle();
    last_good = 8'hA5;
    tests_run++; if (got_q.size() !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    tests_run++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", rx_data); end
    tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL single_err: got %0d expected 0", err_cnt); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    idle_ticks(2 * OS);
    repeat (3) @(negedge clk);
    tests_run++; if (got_q.size() !== 0) begin fails++; $display("FAIL glitch_valid: got %0d pulses expected 0", got_q.size()); end
    tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL glitch_err: got %0d expected 0", err_cnt); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    tests_run++; if (rx_data !== last_good) begin fails++; $display("FAIL glitch_data: got %h expected %h", rx_data, last_good); end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(40);
    settle();
    tests_run++; if (err_cnt !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d expected 1", err_cnt); end
    tests_run++; if (got_q.size() !== 0) begin fails++; $display("FAIL ferr_valid: got %0d expected 0", got_q.size()); end
    tests_run++; if (rx_data !== last_good) begin fails++; $display("FAIL ferr_data_hold: got %h expected %h", rx_data, last_good); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy: got %b expected 0", busy); end
    send_frame(8'h81, 1'b1);
    settle();
    last_good = 8'h81;
    tests_run++; if (got_q.size() !== 1) begin fails++; $display("FAIL ferr_recover_count: got %0d expected 1", got_q.size()); end
    tests_run++; if (rx_data !== 8'h81) begin fails++; $display("FAIL ferr_recover_data: got %h expected 81", rx_data); end
    tests_run++; if (err_cnt !== 1) begin fails++; $display("FAIL ferr_recover_err: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_v[2];
    exp_v[0] = 8'h00;
    exp_v[1] = 8'hFF;
    clear_mon();
    send_frame(exp_v[0], 1'b1);
    send_frame(exp_v[1], 1'b1);
    settle();
    last_good = exp_v[1];
    tests_run++; if (got_q.size() !== 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < got_q.size()) begin
        tests_run++;
        if (got_q[i] !== exp_v[i]) begin fails++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_v[i]); end
      end
    end
    tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL b2b_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_slow_tick();
    tick_div = 5;
    clear_mon();
    send_frame(8'h5A, 1'b1);
    settle();
    last_good = 8'h5A;
    tests_run++; if (got_q.size() !== 1) begin fails++; $display("FAIL slow_count: got %0d expected 1", got_q.size()); end
    tests_run++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL slow_data: got %h expected 5a", rx_data); end
    tests_run++; if (max_valid_run !== 1) begin fails++; $display("FAIL slow_valid_width: got %0d expected 1", max_valid_run); end
    tests_run++; if (both_hi !== 0) begin fails++; $display("FAIL slow_both_high: got %0d expected 0", both_hi); end
    tick_div = 1;
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d;
    d = 8'hC3;
    tick_div = 1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    @(negedge clk);
    rx = d[3];
    wait_ticks(OS / 2);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests_run++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
    tests_run++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL midrst_pulses: got valid=%b err=%b expected 0 0", rx_valid, frame_err); end
    rx = 1'b1;
    clear_mon();
    repeat (5) @(negedge clk);
    arst_n = 1'b1;
    last_good = 8'h00;
    idle_ticks(4 * OS);
    send_frame(8'h7E, 1'b1);
    settle();
    last_good = 8'h7E;
    tests_run++; if (got_q.size() !== 1) begin fails++; $display("FAIL midrst_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++; if (got_q[0] !== 8'h7E) begin fails++; $display("FAIL midrst_word: got %h expected 7e", got_q[0]); end
    end
    tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL midrst_err: got %0d expected 0", err_cnt); end
  endtask

  // Random frames, gaps and tick rates; the model just sorts frames by stop-bit value.
  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    int            exp_err;
    logic [DW-1:0] d;
    logic          stop;
    int            gap;
    exp_err = 0;
    tick_div = int'($urandom_range(1, 3));
    clear_mon();
    for (int f = 0; f < 8; f++) begin
      d    = DW'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = int'($urandom_range(0, 12));
      if (!stop && gap < 3) gap = 3;
      send_frame(d, stop);
      if (stop) begin
        exp_q.push_back(d);
        last_good = d;
      end else begin
        exp_err++;
      end
      if (gap > 0) idle_ticks(gap);
    end
    settle();
    tests_run++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    tests_run++; if (err_cnt !== exp_err) begin fails++; $display("FAIL rand_err: got %0d expected %0d", err_cnt, exp_err); end
    tests_run++; if (rx_data !== last_good) begin fails++; $display("FAIL rand_last_data: got %h expected %h", rx_data, last_good); end
    tests_run++; if (both_hi !== 0) begin fails++; $display("FAIL rand_both_high: got %0d expected 0", both_hi); end
    tick_div = 1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_slow_tick();
    test_reset_mid_frame();
    for (int r = 0; r < 3; r++) test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage, the line-side counterpart of the team's UART transmitter. It samples the asynchronous `rx` line using the shared 16x oversampling `tick`, recovers 8N1 frames (start bit, DATA_WIDTH data bits LSB first, one stop bit), and presents each received word with a one-cycle valid pulse. It also flags framing errors. It sits between the board pin and the microprocessor's input register/FIFO.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥4.
- `clk` input 1: system clock.
- `arst_n` input 1: reset, asynchronous, active-low. Clock is `clk`.
- `rx` input 1: asynchronous serial line. Idle level is 1.
- `tick` input 1: single-`clk`-cycle strobe at OVERSAMPLE × baud rate.
- `rx_data` output DATA_WIDTH: last correctly framed word.
- `rx_valid` output 1: one-cycle pulse when `rx_data` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- Synchronizer: `rx` passes through two flops, both reset to 1. All logic below uses the synchronized value `rx_s`.
- Sample counter `s_cnt` has width $clog2(OVERSAMPLE). Bit counter `n_cnt` has width $clog2(DATA_WIDTH+1). Shift register `sh` is DATA_WIDTH bits wide.
- Counters advance only in cycles where `tick`=1. With no tick, all state holds.
- States:
  - IDLE: when `rx_s`=0, go to START and set `s_cnt`=0. Otherwise stay. Ticks are not needed to leave IDLE.
  - START: on each tick, `s_cnt`++. On the tick where `s_cnt`==OVERSAMPLE/2−1 (mid-bit):
    - If `rx_s`=0, go to DATA with `s_cnt`=0 and `n_cnt`=0.
    - If `rx_s`=1, treat it as a glitch and return to IDLE with no output.
  - DATA: on each tick, `s_cnt`++. On the tick where `s_cnt`==OVERSAMPLE−1:
    - Shift right with `rx_s` entering the MSB, set `s_cnt`=0, `n_cnt`++.
    - When `n_cnt` reaches DATA_WIDTH, go to STOP.
  - STOP: on the tick where `s_cnt`==OVERSAMPLE−1:
    - If `rx_s`=1, load `rx_data`←`sh`, pulse `rx_valid`, and go to IDLE.
    - If `rx_s`=0, pulse `frame_err`, leave `rx_data` unchanged, and go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- Because LSB comes first, the first data bit ends in `sh[0]` after DATA_WIDTH shifts.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: state IDLE, `s_cnt`=0, `n_cnt`=0, `sh`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, synchronizer flops = 1.
- A falling edge on `rx` reaches `rx_s` 2 `clk` cycles later. The state moves to START on the next edge, and `busy` rises with it.
- The data bit k sample point is OVERSAMPLE/2 + (k+1)·OVERSAMPLE ticks after the START entry tick count begins, i.e. mid-bit.
- `rx_valid` / `frame_err` are registered. Each is high for exactly the one `clk` cycle after the clock edge that consumed the stop-sample tick. `rx_data` changes on that same edge and then holds until the next valid frame.
- Total latency is ≈ (DATA_WIDTH+1.5)·OVERSAMPLE ticks + 3 clk from the start edge to `rx_valid`.
- Back-to-back frames: returning to IDLE in the cycle after the stop sample lets a start bit that immediately follows the stop bit be detected within that bit. No frame is lost.
- Asserting `arst_n` mid-frame aborts immediately to reset values. After release, a partial frame in progress is ignored until the line is seen at 0 again from IDLE.

## Test plan
- 8N1 frame 0xA5 at OVERSAMPLE=16 with tick every clk → one `rx_valid` pulse, `rx_data`=0xA5, `frame_err`=0, `busy` back to 0.
- `rx` low for only 4 ticks then high → no `rx_valid`, no `frame_err`, state returns to IDLE, `rx_data` unchanged.
- Frame 0x3C with stop bit 0, line held low 40 ticks, then high, then valid frame 0x81 → `frame_err` pulse, `rx_data` stays 0x3C-free (previous value). The second frame then gives `rx_valid` with `rx_data`=0x81.
- Back-to-back frames 0x00 then 0xFF with zero idle gap → two `rx_valid` pulses, values 0x00 then 0xFF.
- Tick every 5 clk cycles, frame 0x5A → `rx_data`=0x5A. `rx_valid` is exactly 1 clk wide.
- Assert `arst_n` during data bit 3 of 0xC3, release, then send 0x7E → all outputs return to their reset values at reset. The only subsequent `rx_valid` carries 0x7E.
